// File: rtl/fetch_icache_responder.sv
// Direct-mapped instruction cache read port with single-outstanding line refill.
// Optional ICACHE_PERF_COUNTER_EN adds saturating hit/miss counters.
module fetch_icache_responder #(
  parameter int FETCH_WIDTH = 2,
  parameter int LINE_INSN   = 4,
  parameter int INDEX_BIT   = 6,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      icRE,
  input  logic [ADDR_WIDTH-1:0]     icReadAddrIn,
  output logic [FETCH_WIDTH-1:0]    icReadHit,
  output logic [FETCH_WIDTH*32-1:0] icReadDataOut,
  input  logic                      flush,
  output logic                      memReq,
  output logic [ADDR_WIDTH-1:0]     memReqAddr,
  input  logic                      memReqReady,
  input  logic                      memRspValid,
  input  logic [LINE_INSN*32-1:0]   memRspData
`ifdef ICACHE_PERF_COUNTER_EN
  ,
  output logic [31:0]               perfHitCount,
  output logic [31:0]               perfMissCount
`endif
);

  localparam int WOFF_W   = $clog2(LINE_INSN);
  localparam int OFF_BITS = WOFF_W + 2;
  localparam int TAG_W    = ADDR_WIDTH - INDEX_BIT - OFF_BITS;
  localparam int LINES    = 1 << INDEX_BIT;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_e;
  typedef logic [LINE_INSN-1:0][31:0] line_t;

  state_e                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic                           abort_q, abort_d;
  line_t                          fill_data_q, fill_data_d;
  logic [LINES-1:0]               valid_q, valid_d;
  logic [FETCH_WIDTH-1:0]         hit_q, hit_d;
  logic [FETCH_WIDTH-1:0][31:0]   data_q, data_d;

  line_t                          data_mem [LINES];
  logic [TAG_W-1:0]               tag_mem  [LINES];

  logic [INDEX_BIT-1:0]           rd_idx, fill_idx;
  logic [TAG_W-1:0]               rd_tag, fill_tag;
  logic [WOFF_W-1:0]              rd_woff;
  line_t                          rd_line;
  logic                           line_hit, rd_en, fill_we, go_req;
  logic [FETCH_WIDTH-1:0]         slot_in_line;
  logic [FETCH_WIDTH-1:0][31:0]   slot_word;

  assign rd_idx   = icReadAddrIn[OFF_BITS +: INDEX_BIT];
  assign rd_tag   = icReadAddrIn[ADDR_WIDTH-1 -: TAG_W];
  assign rd_woff  = icReadAddrIn[OFF_BITS-1:2];
  assign fill_idx = addr_q[OFF_BITS +: INDEX_BIT];
  assign fill_tag = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign rd_line  = data_mem[rd_idx];

  // An unwritten tag entry is masked by its cleared valid bit.
  assign line_hit = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_en    = (state_q == S_IDLE) && icRE && !flush;
  assign fill_we  = (state_q == S_FILL) && !abort_q && !flush;

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_slot
    logic [WOFF_W:0] wsum;
    assign wsum            = {1'b0, rd_woff} + (WOFF_W+1)'(g);
    assign slot_in_line[g] = (wsum < (WOFF_W+1)'(LINE_INSN));
    assign slot_word[g]    = rd_line[wsum[WOFF_W-1:0]];
  end

  // NOTE: every comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    hit_d  = '0;
    data_d = '0;
    if (rd_en && line_hit) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (slot_in_line[i]) begin
          hit_d[i]  = 1'b1;
          data_d[i] = slot_word[i];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    abort_d     = abort_q;
    fill_data_d = fill_data_q;
    memReq      = 1'b0;
    go_req      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (icRE && !flush && !line_hit) begin
          go_req  = 1'b1;
          state_d = S_REQ;
          addr_d  = {rd_tag, rd_idx, {OFF_BITS{1'b0}}};
          abort_d = 1'b0;
        end
      end
      S_REQ: begin
        memReq = 1'b1;
        if (flush)       abort_d = 1'b1;
        if (memReqReady) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush) abort_d = 1'b1;
        if (memRspValid) begin
          fill_data_d = memRspData;
          state_d     = S_FILL;
        end
      end
      S_FILL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Flush overrides a same-cycle install.
  always_comb begin
    valid_d = valid_q;
    if (fill_we) valid_d[fill_idx] = 1'b1;
    if (flush)   valid_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      abort_q     <= 1'b0;
      fill_data_q <= '0;
      valid_q     <= '0;
      hit_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      abort_q     <= abort_d;
      fill_data_q <= fill_data_d;
      valid_q     <= valid_d;
      hit_q       <= hit_d;
      data_q      <= data_d;
    end
  end

  // NOTE: the data/tag arrays have no reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[fill_idx] <= fill_data_q;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

  assign icReadHit     = hit_q;
  assign icReadDataOut = data_q;
  assign memReqAddr    = addr_q;

`ifdef ICACHE_PERF_COUNTER_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (rd_en && line_hit && (hit_cnt_q != '1)) hit_cnt_d  = hit_cnt_q + 32'd1;
    if (go_req && (miss_cnt_q != '1))           miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign perfHitCount  = hit_cnt_q;
  assign perfMissCount = miss_cnt_q;
`endif

endmodule

// File: doc/fetch_icache_responder.md
FETCH_ICACHE_RESPONDER -- requirements
Module: fetch_icache_responder

Interface
REQ-001 Parameter FETCH_WIDTH, default 2: instructions returned per access.
REQ-002 Parameter LINE_INSN, default 4: 32-bit instructions per cache line (power of two, >= FETCH_WIDTH).
REQ-003 Parameter INDEX_BIT, default 6: index width, giving 64 direct-mapped lines.
REQ-004 Parameter ADDR_WIDTH, default 32: physical address width.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port icRE, input, 1: fetch read enable.
REQ-008 Port icReadAddrIn, input, ADDR_WIDTH: head fetch address; bits [1:0] are ignored.
REQ-009 Port icReadHit, output, FETCH_WIDTH: per-slot hit flags.
REQ-010 Port icReadDataOut, output, FETCH_WIDTH x 32: per-slot instruction words.
REQ-011 Port flush, input, 1: invalidate the whole cache.
REQ-012 Port memReq, output, 1: refill request valid.
REQ-013 Port memReqAddr, output, ADDR_WIDTH: line-aligned refill address.
REQ-014 Port memReqReady, input, 1: memory accepts the request.
REQ-015 Port memRspValid, input, 1: refill data valid.
REQ-016 Port memRspData, input, LINE_INSN x 32: refill line data; word 0 is at the lowest address.

Function
REQ-017 Address fields: offset = address bits [log2(LINE_INSN)+1 : 0]; index = the next INDEX_BIT bits; tag = the remaining upper bits.
REQ-018 Read latency is 1 cycle: icRE/icReadAddrIn sampled at edge N; icReadHit/icReadDataOut are registered and valid after edge N.
REQ-019 Slot i hit conditions, all required: icRE sampled high; FSM was IDLE; line valid; tag match; word offset + i < LINE_INSN.
REQ-020 A slot whose word falls past the end of the line reports a miss and never triggers a refill.
REQ-021 icReadDataOut slot i holds line word (offset + i) on a hit; on a miss its value is don't-care, but it is never X after reset.
REQ-022 FSM states: IDLE, REQ, WAIT, FILL.
REQ-023 IDLE -> REQ when icRE is high, slot 0 misses and flush is low; the line address is latched.
REQ-024 REQ: memReq is 1 and memReqAddr holds the latched address; memReq stays asserted until memReqReady is high; then -> WAIT.
REQ-025 WAIT: memReq is 0; on memRspValid -> FILL, capturing memRspData.
REQ-026 FILL: write data and tag, set the valid bit for the latched index; then -> IDLE.
REQ-027 A read of the refilled line is a hit no earlier than the cycle after FILL.
REQ-028 In REQ, WAIT and FILL, icRE is ignored and all icReadHit bits are 0 in the following cycle.
REQ-029 flush clears every valid bit in one cycle.
REQ-030 flush in REQ or WAIT: the current request still completes its handshake, but the line is not installed; FILL returns to IDLE with no write.
REQ-031 flush and a FILL write in the same cycle: flush wins and the line stays invalid.
REQ-032 flush in IDLE suppresses a new miss in that cycle, and icReadHit is all 0 in the next cycle.
REQ-033 memRspValid outside WAIT is ignored.

Reset
REQ-034 rst clears all valid bits and sets the FSM to IDLE.
REQ-035 On rst, icReadHit, memReq, memReqAddr and icReadDataOut all go to 0.
REQ-036 rst mid-refill abandons the refill; a later memRspValid is ignored.

Configuration
REQ-037 With ICACHE_PERF_COUNTER_EN defined:
- Outputs perfHitCount (32 bits) and perfMissCount (32 bits) are added.
- perfHitCount increments when slot 0 hits.
- perfMissCount increments on each IDLE->REQ transition.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
REQ-038 Without ICACHE_PERF_COUNTER_EN, the counters and these ports are absent; behaviour is otherwise identical.

Verification
REQ-039 Cold miss: after reset, icRE=1, addr=0x1000.
- Response: memReq=1 with memReqAddr=0x1000.
- Ready, then response words 0xA0..0xA3.
- Re-read of 0x1000 next cycle: icReadHit=11, data={0xA0,0xA1}.
REQ-040 Line crossing: line at 0x1000 installed, read addr=0x100C.
- Response: icReadHit=01, data slot0=0xA3, no memReq.
REQ-041 Conflict: install 0x1000, then read 0x1400 (same index, different tag).
- Response: miss and refill; a later read of 0x1000 misses.
REQ-042 Flush during WAIT: miss on 0x2000, flush=1 in WAIT, response delivered.
- Response: no install; re-read of 0x2000 issues memReq again.
REQ-043 Backpressure: memReqReady held 0 for 5 cycles.
- Response: memReq and memReqAddr stable all 5 cycles; icReadHit=0 throughout.
REQ-044 Reset mid-WAIT, then memRspValid=1.
- Response: FSM IDLE, line 0x3000 not installed, memReq=0.
